expr_eval: RTL and testbench
============================

Name: expr_eval

Overview:
- Downstream consumer of the character-stream recognizer: takes the same 8-bit ASCII stream, one character per clk, and computes the value of the expression.
- Grammar: single-digit operands '0'..'9' alternating with operators '+' and '*'. Evaluation follows precedence, so '*' binds tighter than '+'.
- Publishes a running result, a valid flag and sticky error/overflow flags, for use by the display/checker stage.

Parameters:
- W, 16, width of result and internal accumulators; arithmetic is modulo 2^W.

Ports:
- clk  input  1  clock, rising edge.
- clr  input  1  reset, asynchronous, active-high.
- in  input  8  ASCII character, sampled every rising clk edge while clr is low.
- result  output  W  value of the expression consumed so far (sum + prod), modulo 2^W; forced to 0 in ERR.
- valid  output  1  high when the stream so far is a complete legal expression, i.e. it ends on a digit.
- err  output  1  sticky; high once an illegal character or sequence is seen.
- ovf  output  1  sticky; high once any intermediate value reaches or exceeds 2^W.

Behaviour:
- Reset: applying clr asynchronously sets state=START, sum=0, prod=0, op=ADD, ovf=0. Outputs on reset: result=0, valid=0, err=0, ovf=0.
- An initial block gives the same values for simulation.
- Character classes:
  - DIG: 8'h30..8'h39, with d = in - 8'h30.
  - OPC: '+' (8'h2B) or '*' (8'h2A).
  - BAD: everything else.
- States: START (expect first digit), NUM (last char was a digit), OPR (last char was an operator), ERR (absorbing).
- START:
  - DIG: prod<=d, sum<=0 -> NUM.
  - OPC or BAD -> ERR.
- NUM:
  - '+': op<=ADD -> OPR.
  - '*': op<=MUL -> OPR.
  - DIG or BAD -> ERR (multi-digit operands are illegal).
- OPR:
  - DIG with op=MUL: prod<=prod*d -> NUM.
  - DIG with op=ADD: sum<=sum+prod, prod<=d -> NUM.
  - OPC or BAD -> ERR.
- ERR: stays in ERR until clr; sum, prod and op are held.
- Output timing:
  - valid = (state==NUM) and err = (state==ERR), both combinational from the state register.
  - result = (state==ERR) ? 0 : sum+prod, truncated to W bits.
  - The character sampled at edge k is reflected in the outputs after edge k (one-cycle latency, same as the recognizer).
- In OPR, result still shows the value before the operator and valid=0.
- Overflow detection:
  - On every DIG accepted in NUM-producing transitions, compute at W+4 bits: new_prod (prod*d or d), new_sum (sum+prod or sum), and new_sum+new_prod.
  - If any of these is >= 2^W, set ovf<=1.
  - Stored registers keep the low W bits. ovf is never cleared except by clr.
- ovf and err are independent. Entering ERR does not alter ovf.
- clr asserted mid-expression wins over any in value on the same edge. The first character after clr deasserts is treated as the first character of a new expression.

Decomposition:
- Shared package/header (expr_defs): state encodings START/NUM/OPR/ERR (2 bits), op encoding ADD/MUL, ASCII constants CH_0, CH_9, CH_PLUS, CH_STAR.
- The recognizer's FSM encoding aligns with these constants.
- Sub-module char_class: combinational in -> {is_dig, is_op, is_mul, d[3:0]}. It is shared by the recognizer and evaluator.
- Remaining logic (FSM and datapath) lives in expr_eval.

Test Plan:
- clr pulse, then "1+2*3": after '1' result=1 valid=1; after '+' valid=0 result=1; after '3' result=7 valid=1 err=0 ovf=0.
- "2*3*4+5": after '4' result=24; after '5' result=29 valid=1.
- "+3": ERR after '+', err=1 valid=0 result=0, and stays so through '3'. "12": err=1 after '2'. "3a": err=1 after 'a'.
- W=4, "9*9": ovf=1 after second '9', result=81 mod 16 = 1, valid=1. "7+9" with W=4: ovf=1, result=0.
- Async clr raised mid-edge-cycle during "5*" (in OPR): outputs zero immediately without a clk edge. After release, "8" gives result=8 valid=1 ovf=0 err=0.
- From ERR, clr then "0*9+0": after each digit result=0, 0, 0; valid high after the three digits; err=0.

Source files
------------

// File: rtl/expr_eval_pkg.sv
// expr_eval_pkg: shared definitions for the expression stream stage.
//   state_t : evaluator FSM encoding (START/NUM/OPR/ERR, 2 bits), the same
//             encoding the upstream recognizer uses.
//   op_t    : pending operator (ADD/MUL).
//   CH_*    : ASCII constants for the character classes.
package expr_eval_pkg;

    typedef enum logic [1:0] {
        START = 2'd0,   // expecting the first digit
        NUM   = 2'd1,   // last character was a digit
        OPR   = 2'd2,   // last character was an operator
        ERR   = 2'd3    // absorbing until clr
    } state_t;

    typedef enum logic {
        ADD = 1'b0,
        MUL = 1'b1
    } op_t;

    localparam logic [7:0] CH_0    = 8'h30;
    localparam logic [7:0] CH_9    = 8'h39;
    localparam logic [7:0] CH_PLUS = 8'h2B;
    localparam logic [7:0] CH_STAR = 8'h2A;

endpackage

// File: rtl/expr_eval_if.sv
// expr_eval_if: character stream in, evaluation status out.
//   in        : ASCII character, consumed on every rising clk edge while clr
//               is low. There is no valid/ready handshake: the stream is
//               free-running, one character per cycle, never back-pressured.
//   result    : sum + prod of the expression so far (W bits), 0 in ERR
//   valid     : stream so far is a complete legal expression
//   err, ovf  : sticky error / overflow flags
//   dbg_state : current FSM state, for checkers and debug
// master = the stream source / observer, slave = the evaluator.
interface expr_eval_if
    import expr_eval_pkg::*;
#(
    parameter int W = 16
);
    logic [7:0]   in;
    logic [W-1:0] result;
    logic         valid;
    logic         err;
    logic         ovf;
    state_t       dbg_state;

    modport master (
        output in,
        input  result, valid, err, ovf, dbg_state
    );

    modport slave (
        input  in,
        output result, valid, err, ovf, dbg_state
    );
endinterface

// File: rtl/expr_eval_char_class.sv
// expr_eval_char_class: combinational ASCII classifier shared by the
// recognizer and the evaluator.
//   ch     : input character
//   is_dig : '0'..'9'
//   is_op  : '+' or '*'
//   is_mul : '*'
//   d      : digit value (0 when ch is not a digit)
module expr_eval_char_class
    import expr_eval_pkg::*;
(
    input  logic [7:0] ch,
    output logic       is_dig,
    output logic       is_op,
    output logic       is_mul,
    output logic [3:0] d
);
    always_comb begin
        is_dig = (ch >= CH_0) && (ch <= CH_9);
        is_op  = (ch == CH_PLUS) || (ch == CH_STAR);
        is_mul = (ch == CH_STAR);
        // Digits live at 0x30..0x39, so the low nibble is ch - '0'.
        d      = is_dig ? ch[3:0] : 4'd0;
    end
endmodule

// File: rtl/expr_eval.sv
// expr_eval: evaluates a stream of single-digit operands separated by '+'
// and '*', with '*' binding tighter than '+'. The pending product lives in
// prod, everything already added up lives in sum, so the value so far is
// always sum + prod.
//   clk : rising-edge clock
//   clr : asynchronous active-high clear
//   bus : expr_eval_if.slave (in, result, valid, err, ovf, dbg_state)
// The character sampled at edge k is reflected in the outputs after edge k.
module expr_eval
    import expr_eval_pkg::*;
#(
    parameter int W = 16
)(
    input  logic        clk,
    input  logic        clr,
    expr_eval_if.slave  bus
);
    // Four extra bits hold prod*9 + sum + prod for W-bit operands exactly,
    // so overflow is visible in the upper bits.
    localparam int EW = W + 4;

    state_t       state_q, state_d;
    op_t          op_q, op_d;
    logic [W-1:0] sum_q, sum_d;
    logic [W-1:0] prod_q, prod_d;
    logic         ovf_q, ovf_d;

    logic         is_dig, is_op, is_mul;
    logic [3:0]   d;

    logic          take_dig;
    logic [EW-1:0] d_x, prod_x, sum_x;
    logic [EW-1:0] new_prod, new_sum, new_total;

    expr_eval_char_class u_class (
        .ch     (bus.in),
        .is_dig (is_dig),
        .is_op  (is_op),
        .is_mul (is_mul),
        .d      (d)
    );

    // State register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= START;
            op_q    <= ADD;
            sum_q   <= '0;
            prod_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sum_q   <= sum_d;
            prod_q  <= prod_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sum_d    = sum_q;
        prod_d   = prod_q;
        ovf_d    = ovf_q;
        take_dig = 1'b0;

        d_x      = EW'(d);
        prod_x   = EW'(prod_q);
        sum_x    = EW'(sum_q);
        new_prod = prod_x;
        new_sum  = sum_x;

        case (state_q)
            START: begin
                if (is_dig) begin
                    take_dig = 1'b1;
                    new_prod = d_x;
                    new_sum  = '0;
                    state_d  = NUM;
                end else begin
                    state_d = ERR;
                end
            end
            NUM: begin
                if (is_op) begin
                    op_d    = is_mul ? MUL : ADD;
                    state_d = OPR;
                end else begin
                    // A second digit would be a multi-digit operand.
                    state_d = ERR;
                end
            end
            OPR: begin
                if (is_dig) begin
                    take_dig = 1'b1;
                    if (op_q == MUL) begin
                        new_prod = prod_x * d_x;
                    end else begin
                        // '+' closes the current product term.
                        new_sum  = sum_x + prod_x;
                        new_prod = d_x;
                    end
                    state_d = NUM;
                end else begin
                    state_d = ERR;
                end
            end
            ERR: begin
                state_d = ERR;
            end
        endcase

        new_total = new_sum + new_prod;

        if (take_dig) begin
            prod_d = new_prod[W-1:0];
            sum_d  = new_sum[W-1:0];
            if ((|new_prod[EW-1:W]) || (|new_sum[EW-1:W]) || (|new_total[EW-1:W])) begin
                ovf_d = 1'b1;
            end
        end
    end

    // Outputs, decoded from registered state only
    always_comb begin
        bus.result    = (state_q == ERR) ? '0 : (sum_q + prod_q);
        bus.valid     = (state_q == NUM);
        bus.err       = (state_q == ERR);
        bus.ovf       = ovf_q;
        bus.dbg_state = state_q;
    end

endmodule

// File: tb/tb_expr_eval.sv
module tb_expr_eval;
    import expr_eval_pkg::*;

    // ---------------- clock / reset ----------------
    logic       clk;
    logic       clr;
    logic [7:0] in_ch;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    expr_eval_if #(.W(16)) bus16 ();
    expr_eval_if #(.W(4))  bus4  ();

    assign bus16.in = in_ch;
    assign bus4.in  = in_ch;

    expr_eval #(.W(16)) dut16 (.clk(clk), .clr(clr), .bus(bus16.slave));
    expr_eval #(.W(4))  dut4  (.clk(clk), .clr(clr), .bus(bus4.slave));

    // ---------------- scoreboard counters ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check16(input string tag, input int r, input bit v, input bit e, input bit o);
        check({tag, ".result"}, 32'(bus16.result), r);
        check({tag, ".valid"},  32'(bus16.valid),  32'(v));
        check({tag, ".err"},    32'(bus16.err),    32'(e));
        check({tag, ".ovf"},    32'(bus16.ovf),    32'(o));
    endtask

    task automatic check4(input string tag, input int r, input bit v, input bit e, input bit o);
        check({tag, ".result"}, 32'(bus4.result), r);
        check({tag, ".valid"},  32'(bus4.valid),  32'(v));
        check({tag, ".err"},    32'(bus4.err),    32'(e));
        check({tag, ".ovf"},    32'(bus4.ovf),    32'(o));
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic [7:0] ch);
        in_ch = ch;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    // ---------------- behavioural reference model ----------------
    // Tracks the expression as "sum of closed terms" + "current term",
    // stored modulo 2^w, with overflow judged on exact integer values.
    typedef struct {
        longint sum;
        longint prod;
        bit     mul;
        bit     ovf;
        bit     dead;
        bit     expect_dig;
        bit     started;
    } model_t;

    function automatic model_t model_reset();
        model_t m;
        m.sum = 0; m.prod = 0; m.mul = 0; m.ovf = 0;
        m.dead = 0; m.expect_dig = 1; m.started = 0;
        return m;
    endfunction

    function automatic void model_step(inout model_t m, input logic [7:0] ch, input int w);
        longint lim, ns, np;
        bit dig, op;
        lim = longint'(1) << w;
        dig = (ch >= 8'h30) && (ch <= 8'h39);
        op  = (ch == 8'h2B) || (ch == 8'h2A);
        if (m.dead) return;
        if (m.expect_dig) begin
            if (!dig) begin
                m.dead = 1;
                return;
            end
            if (!m.started) begin
                np = longint'(ch) - 48; ns = 0;
            end else if (m.mul) begin
                np = m.prod * (longint'(ch) - 48); ns = m.sum;
            end else begin
                ns = m.sum + m.prod; np = longint'(ch) - 48;
            end
            if (np >= lim || ns >= lim || ns + np >= lim) m.ovf = 1;
            m.prod = np % lim;
            m.sum  = ns % lim;
            m.started = 1;
            m.expect_dig = 0;
        end else begin
            if (!op) begin
                m.dead = 1;
                return;
            end
            m.mul = (ch == 8'h2A);
            m.expect_dig = 1;
        end
    endfunction

    function automatic int model_result(input model_t m, input int w);
        longint lim;
        lim = longint'(1) << w;
        return m.dead ? 0 : int'((m.sum + m.prod) % lim);
    endfunction

    // ---------------- vector table (W=16 instance) ----------------
    typedef struct {
        bit          clr_first;
        logic [7:0]  ch;
        int          result;
        bit          valid;
        bit          err;
        bit          ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input bit c, input logic [7:0] ch, input int r,
                           input bit v, input bit e, input bit o);
        vec_t x;
        x.clr_first = c; x.ch = ch; x.result = r; x.valid = v; x.err = e; x.ovf = o;
        vecs.push_back(x);
    endtask

    logic [7:0] bad_chars [6];
    model_t     m16, m4;

    initial begin
        bad_chars[0] = 8'h2F; bad_chars[1] = 8'h3A; bad_chars[2] = 8'h29;
        bad_chars[3] = 8'h2C; bad_chars[4] = "a";   bad_chars[5] = 8'h20;

        // "1+2*3"
        add_vec(1, "1", 1, 1, 0, 0);
        add_vec(0, "+", 1, 0, 0, 0);
        add_vec(0, "2", 3, 1, 0, 0);
        add_vec(0, "*", 3, 0, 0, 0);
        add_vec(0, "3", 7, 1, 0, 0);
        // "2*3*4+5"
        add_vec(1, "2", 2, 1, 0, 0);
        add_vec(0, "*", 2, 0, 0, 0);
        add_vec(0, "3", 6, 1, 0, 0);
        add_vec(0, "*", 6, 0, 0, 0);
        add_vec(0, "4", 24, 1, 0, 0);
        add_vec(0, "+", 24, 0, 0, 0);
        add_vec(0, "5", 29, 1, 0, 0);
        // "+3" errors at once and stays there
        add_vec(1, "+", 0, 0, 1, 0);
        add_vec(0, "3", 0, 0, 1, 0);
        // "12" multi-digit operand
        add_vec(1, "1", 1, 1, 0, 0);
        add_vec(0, "2", 0, 0, 1, 0);
        // "3a"
        add_vec(1, "3", 3, 1, 0, 0);
        add_vec(0, "a", 0, 0, 1, 0);
        // clr out of ERR, then "0*9+0"
        add_vec(1, "0", 0, 1, 0, 0);
        add_vec(0, "*", 0, 0, 0, 0);
        add_vec(0, "9", 0, 1, 0, 0);
        add_vec(0, "+", 0, 0, 0, 0);
        add_vec(0, "0", 0, 1, 0, 0);
        // 9^6 = 531441 wraps at 2^16 to 7153 and sets ovf
        add_vec(1, "9", 9, 1, 0, 0);
        add_vec(0, "*", 9, 0, 0, 0);
        add_vec(0, "9", 81, 1, 0, 0);
        add_vec(0, "*", 81, 0, 0, 0);
        add_vec(0, "9", 729, 1, 0, 0);
        add_vec(0, "*", 729, 0, 0, 0);
        add_vec(0, "9", 6561, 1, 0, 0);
        add_vec(0, "*", 6561, 0, 0, 0);
        add_vec(0, "9", 59049, 1, 0, 0);
        add_vec(0, "*", 59049, 0, 0, 0);
        add_vec(0, "9", 7153, 1, 0, 1);
        add_vec(0, "+", 7153, 0, 0, 1);
        add_vec(0, "1", 7154, 1, 0, 1);
        // ovf sticks into ERR, then clr clears it
        add_vec(0, "5", 0, 0, 1, 1);
        add_vec(1, "1", 1, 1, 0, 0);

        // ---------------- reset state ----------------
        clr   = 1'b1;
        in_ch = "7";
        repeat (2) @(posedge clk);
        #1;
        check16("reset16", 0, 0, 0, 0);
        check4("reset4", 0, 0, 0, 0);
        check("reset16.state", 32'(bus16.dbg_state), 32'(START));
        clr = 1'b0;

        // ---------------- table ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].clr_first) pulse_clr();
            step(vecs[i].ch);
            check16($sformatf("vec%0d", i), vecs[i].result, vecs[i].valid, vecs[i].err, vecs[i].ovf);
        end

        // ---------------- W=4 overflow sequences ----------------
        pulse_clr();
        step("9"); step("*"); step("9");
        check4("w4_9x9", 1, 1, 0, 1);
        pulse_clr();
        step("7"); step("+"); step("9");
        check4("w4_7p9", 0, 1, 0, 1);

        // ---------------- async clr in OPR ----------------
        pulse_clr();
        step("5"); step("*");
        check16("opr16", 5, 0, 0, 0);
        check("opr16.state", 32'(bus16.dbg_state), 32'(OPR));
        pulse_clr();
        step("9"); step("*"); step("9"); step("*");
        check4("opr4", 1, 0, 0, 1);
        #2 clr = 1'b1;
        #1;
        check16("async16", 0, 0, 0, 0);
        check4("async4", 0, 0, 0, 0);
        // clr still high across an edge: the character is ignored
        in_ch = "7";
        @(posedge clk);
        #1;
        check16("clr_hold16", 0, 0, 0, 0);
        clr = 1'b0;
        step("8");
        check16("after_clr16", 8, 1, 0, 0);
        check4("after_clr4", 8, 1, 0, 0);

        // ---------------- randomized vs model ----------------
        pulse_clr();
        m16 = model_reset();
        m4  = model_reset();
        for (int n = 0; n < 800; n++) begin
            logic [7:0] ch;
            int r;
            if ($urandom_range(0, 24) == 0 || (m16.dead && $urandom_range(0, 3) == 0)) begin
                pulse_clr();
                m16 = model_reset();
                m4  = model_reset();
            end
            r = $urandom_range(0, 29);
            if (r == 0) begin
                ch = bad_chars[$urandom_range(0, 5)];
            end else if ((r == 1) != m16.expect_dig) begin
                ch = 8'(8'h30 + $urandom_range(0, 9));
            end else begin
                ch = $urandom_range(0, 1) ? 8'h2A : 8'h2B;
            end
            step(ch);
            model_step(m16, ch, 16);
            model_step(m4, ch, 4);
            check16($sformatf("rnd16_%0d", n), model_result(m16, 16),
                    !m16.dead && !m16.expect_dig, m16.dead, m16.ovf);
            check4($sformatf("rnd4_%0d", n), model_result(m4, 4),
                   !m4.dead && !m4.expect_dig, m4.dead, m4.ovf);
        end

        // ---------------- report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
